// File: rtl/reflet_ram_arbiter.sv
// Two-client round-robin arbiter for one write port and one registered read port of a reflet RAM.
// Latency: write acked and committed in one cycle; read acked at A, rvalid/rdata at A+2. Losers keep req high until acked.
module reflet_ram_arbiter #(
  parameter int addrSize = 7,
  parameter int depth    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                c0_req,
  input  logic                c0_we,
  input  logic [addrSize-1:0] c0_addr,
  input  logic [depth-1:0]    c0_wdata,
  output logic                c0_ack,
  output logic [depth-1:0]    c0_rdata,
  output logic                c0_rvalid,
  input  logic                c1_req,
  input  logic                c1_we,
  input  logic [addrSize-1:0] c1_addr,
  input  logic [depth-1:0]    c1_wdata,
  output logic                c1_ack,
  output logic [depth-1:0]    c1_rdata,
  output logic                c1_rvalid,
  output logic                ram_reset_n,
  output logic                ram_enable,
  output logic [addrSize-1:0] ram_addr_read,
  output logic [addrSize-1:0] ram_addr_write,
  output logic [depth-1:0]    ram_data_in,
  output logic                ram_write_en,
  input  logic [depth-1:0]    ram_data_out
);

  typedef enum logic {R_IDLE, R_WAIT} rd_state_t;

  rd_state_t           rd_state_q, rd_state_d;
  logic                wr_prio_q, wr_prio_d;
  logic                rd_prio_q, rd_prio_d;
  logic                rd_owner_q, rd_owner_d;
  logic [addrSize-1:0] rd_addr_q, rd_addr_d;
  logic [addrSize-1:0] wr_addr_q, wr_addr_d;
  logic [depth-1:0]    wr_data_q, wr_data_d;
  logic [depth-1:0]    c0_rdata_q, c0_rdata_d;
  logic [depth-1:0]    c1_rdata_q, c1_rdata_d;
  logic                c0_rvalid_q, c0_rvalid_d;
  logic                c1_rvalid_q, c1_rvalid_d;

  logic [1:0] wr_cand, wr_gnt;
  logic [1:0] rd_cand, rd_gnt;

  // Under contention the pointer picks the winner; a lone candidate always wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] cand, input logic prio);
    if (&cand) return prio ? 2'b10 : 2'b01;
    return cand;
  endfunction

  always_comb begin
    wr_cand = {c1_req & c1_we, c0_req & c0_we} & {2{~reset}};
    rd_cand = {c1_req & ~c1_we, c0_req & ~c0_we} & {2{~reset && rd_state_q == R_IDLE}};
    wr_gnt  = rr_pick(wr_cand, wr_prio_q);
    rd_gnt  = rr_pick(rd_cand, rd_prio_q);

    c0_ack = wr_gnt[0] | rd_gnt[0];
    c1_ack = wr_gnt[1] | rd_gnt[1];

    ram_write_en   = |wr_gnt;
    ram_addr_write = wr_addr_q;
    ram_data_in    = wr_data_q;
    if (wr_gnt[0]) begin
      ram_addr_write = c0_addr;
      ram_data_in    = c0_wdata;
    end else if (wr_gnt[1]) begin
      ram_addr_write = c1_addr;
      ram_data_in    = c1_wdata;
    end
    wr_addr_d = ram_addr_write;
    wr_data_d = ram_data_in;
    wr_prio_d = (|wr_gnt) ? wr_gnt[0] : wr_prio_q;

    rd_state_d  = rd_state_q;
    rd_prio_d   = rd_prio_q;
    rd_owner_d  = rd_owner_q;
    rd_addr_d   = rd_addr_q;
    c0_rdata_d  = c0_rdata_q;
    c1_rdata_d  = c1_rdata_q;
    c0_rvalid_d = 1'b0;
    c1_rvalid_d = 1'b0;
    ram_addr_read = rd_addr_q;

    case (rd_state_q)
      R_IDLE: begin
        if (|rd_gnt) begin
          ram_addr_read = rd_gnt[1] ? c1_addr : c0_addr;
          rd_addr_d     = ram_addr_read;
          rd_owner_d    = rd_gnt[1];
          rd_prio_d     = rd_gnt[0];
          rd_state_d    = R_WAIT;
        end
      end
      R_WAIT: begin
        // Address stays on the port: the RAM gates its output on it.
        if (rd_owner_q) begin
          c1_rdata_d  = ram_data_out;
          c1_rvalid_d = 1'b1;
        end else begin
          c0_rdata_d  = ram_data_out;
          c0_rvalid_d = 1'b1;
        end
        rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q  <= R_IDLE;
      wr_prio_q   <= 1'b0;
      rd_prio_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      c0_rdata_q  <= '0;
      c1_rdata_q  <= '0;
      c0_rvalid_q <= 1'b0;
      c1_rvalid_q <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      wr_prio_q   <= wr_prio_d;
      rd_prio_q   <= rd_prio_d;
      rd_owner_q  <= rd_owner_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      c0_rdata_q  <= c0_rdata_d;
      c1_rdata_q  <= c1_rdata_d;
      c0_rvalid_q <= c0_rvalid_d;
      c1_rvalid_q <= c1_rvalid_d;
    end
  end

  assign c0_rdata    = c0_rdata_q;
  assign c1_rdata    = c1_rdata_q;
  assign c0_rvalid   = c0_rvalid_q;
  assign c1_rvalid   = c1_rvalid_q;
  assign ram_reset_n = ~reset;
  assign ram_enable  = ~reset;

endmodule

// File: tb/tb_reflet_ram_arbiter.sv
// Bench for reflet_ram_arbiter with a 128-word behavioural RAM and an 8-bit address bus.
module tb_reflet_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int RAM_SIZE = 128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic c0_req = 0, c0_we = 0, c1_req = 0, c1_we = 0;
  logic [AW-1:0] c0_addr = '0, c1_addr = '0;
  logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;
  logic c0_ack, c1_ack, c0_rvalid, c1_rvalid;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic ram_reset_n, ram_enable, ram_write_en;
  logic [AW-1:0] ram_addr_read, ram_addr_write;
  logic [DW-1:0] ram_data_in, ram_data_out;

  always #5 clk = ~clk;

  reflet_ram_arbiter #(.addrSize(AW), .depth(DW)) dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_ack(c0_ack), .c0_rdata(c0_rdata), .c0_rvalid(c0_rvalid),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_ack(c1_ack), .c1_rdata(c1_rdata), .c1_rvalid(c1_rvalid),
    .ram_reset_n(ram_reset_n), .ram_enable(ram_enable),
    .ram_addr_read(ram_addr_read), .ram_addr_write(ram_addr_write),
    .ram_data_in(ram_data_in), .ram_write_en(ram_write_en),
    .ram_data_out(ram_data_out)
  );

  // Behavioural RAM: registered read, output gated on the live read address.
  logic [DW-1:0] mem [RAM_SIZE];
  logic [DW-1:0] rd_reg;
  always @(posedge clk) begin
    if (!ram_reset_n) begin
      for (int i = 0; i < RAM_SIZE; i++) mem[i] <= '0;
      rd_reg <= '0;
    end else if (ram_enable) begin
      if (ram_write_en && ram_addr_write < RAM_SIZE) mem[ram_addr_write[6:0]] <= ram_data_in;
      rd_reg <= (ram_addr_read < RAM_SIZE) ? mem[ram_addr_read[6:0]] : '0;
    end
  end
  assign ram_data_out = (ram_addr_read < RAM_SIZE) ? rd_reg : '0;

  typedef struct {
    int            c;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  ev_t           wr_q[$];
  ev_t           rdack_q[$];
  logic [DW-1:0] exp_rd0[$];
  logic [DW-1:0] exp_rd1[$];
  int            tmo_cnt = 0;
  bit            done = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (c == 0) begin
      c0_req = r; c0_we = we; c0_addr = a; c0_wdata = d;
    end else begin
      c1_req = r; c1_we = we; c1_addr = a; c1_wdata = d;
    end
  endtask

  task automatic do_req(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 0;
    set_req(c, 1'b1, we, a, d);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (c == 0) ? c0_ack : c1_ack;
    end
    if (!got) tmo_cnt++;
    tick();
    set_req(c, 1'b0, 1'b0, a, d);
  endtask

  task automatic push_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    e.c = c; e.addr = a; e.data = d;
    wr_q.push_back(e);
  endtask

  task automatic push_rd(input int c, input logic [AW-1:0] a);
    ev_t e;
    e.c = c; e.addr = a; e.data = '0;
    rdack_q.push_back(e);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;

    // Write then read back through c0.
    push_wr(0, 8'd3, 8'h5A);
    do_req(0, 1'b1, 8'd3, 8'h5A);
    push_rd(0, 8'd3); exp_rd0.push_back(8'h5A);
    do_req(0, 1'b0, 8'd3, 8'h00);
    repeat (3) tick();

    // Contending writes alternate starting from c0 after reset.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_wr(0, 8'd1, 8'h11);
      push_wr(1, 8'd2, 8'h22);
    end
    set_req(0, 1'b1, 1'b1, 8'd1, 8'h11);
    set_req(1, 1'b1, 1'b1, 8'd2, 8'h22);
    repeat (6) tick();
    set_req(0, 1'b0, 1'b0, 8'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'd0, 8'h00);
    tick();

    // Same-cycle write and read of one address: read sees the old value.
    push_wr(0, 8'd5, 8'hAA);
    push_rd(1, 8'd5); exp_rd1.push_back(8'h00);
    set_req(0, 1'b1, 1'b1, 8'd5, 8'hAA);
    set_req(1, 1'b1, 1'b0, 8'd5, 8'h00);
    tick();
    set_req(0, 1'b0, 1'b0, 8'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'd0, 8'h00);
    repeat (3) tick();
    push_rd(1, 8'd5); exp_rd1.push_back(8'hAA);
    do_req(1, 1'b0, 8'd5, 8'h00);
    repeat (3) tick();

    // Contending reads: one ack every two cycles, alternating.
    for (int i = 0; i < 2; i++) begin
      push_rd(0, 8'd1); exp_rd0.push_back(8'h11);
      push_rd(1, 8'd2); exp_rd1.push_back(8'h22);
    end
    set_req(0, 1'b1, 1'b0, 8'd1, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'd2, 8'h00);
    repeat (8) tick();
    set_req(0, 1'b0, 1'b0, 8'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'd0, 8'h00);
    repeat (3) tick();

    // Out-of-range read returns zero with a normal rvalid.
    push_rd(0, 8'd200); exp_rd0.push_back(8'h00);
    do_req(0, 1'b0, 8'd200, 8'h00);
    repeat (3) tick();

    // Reset during the wait cycle drops the read; RAM is cleared.
    push_rd(0, 8'd1);
    do_req(0, 1'b0, 8'd1, 8'h00);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    push_rd(0, 8'd1); exp_rd0.push_back(8'h00);
    do_req(0, 1'b0, 8'd1, 8'h00);
    repeat (4) tick();
    done = 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
    $fatal(1);
  end

  int            total = 0;
  int            bad = 0;
  bit            rst_prev = 0;
  bit            hold_chk = 0;
  logic [AW-1:0] hold_addr = '0;
  int            ack_cyc [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] wacks, racks;
    ev_t        e;
    logic [DW-1:0] x;
    if (reset) begin
      chk("rst_ack", {30'd0, c1_ack, c0_ack}, 0);
      chk("rst_wen", {31'd0, ram_write_en}, 0);
      chk("rst_ram_en", {30'd0, ram_enable, ram_reset_n}, 0);
      if (rst_prev) begin
        chk("rst_rvalid", {30'd0, c1_rvalid, c0_rvalid}, 0);
        chk("rst_rdata", {16'd0, c1_rdata, c0_rdata}, 0);
        chk("rst_ram_addr", {16'd0, ram_addr_read, ram_addr_write}, 0);
        chk("rst_ram_din", {24'd0, ram_data_in}, 0);
      end
      hold_chk = 0;
    end else begin
      chk("ram_en", {30'd0, ram_enable, ram_reset_n}, 32'd3);
      wacks = {c1_ack & c1_we, c0_ack & c0_we};
      racks = {c1_ack & ~c1_we, c0_ack & ~c0_we};
      if (ram_write_en || wacks != 0) begin
        chk("wr_expected", {31'd0, wr_q.size() != 0}, 1);
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          chk("wr_who", {30'd0, wacks}, (e.c == 1) ? 32'd2 : 32'd1);
          chk("wr_en", {31'd0, ram_write_en}, 1);
          chk("wr_addr", {24'd0, ram_addr_write}, {24'd0, e.addr});
          chk("wr_data", {24'd0, ram_data_in}, {24'd0, e.data});
        end
      end
      if (hold_chk) begin
        chk("rd_addr_hold", {24'd0, ram_addr_read}, {24'd0, hold_addr});
        hold_chk = 0;
      end
      if (racks != 0) begin
        chk("rd_expected", {31'd0, rdack_q.size() != 0}, 1);
        if (rdack_q.size() != 0) begin
          e = rdack_q.pop_front();
          chk("rd_who", {30'd0, racks}, (e.c == 1) ? 32'd2 : 32'd1);
          chk("rd_addr", {24'd0, ram_addr_read}, {24'd0, e.addr});
          hold_addr = e.addr;
          hold_chk = 1;
          ack_cyc[e.c] = cyc;
        end
      end
      if (c0_rvalid) begin
        chk("c0_rvalid_expected", {31'd0, exp_rd0.size() != 0}, 1);
        if (exp_rd0.size() != 0) begin
          x = exp_rd0.pop_front();
          chk("c0_rdata", {24'd0, c0_rdata}, {24'd0, x});
          chk("c0_latency", cyc - ack_cyc[0], 2);
        end
      end
      if (c1_rvalid) begin
        chk("c1_rvalid_expected", {31'd0, exp_rd1.size() != 0}, 1);
        if (exp_rd1.size() != 0) begin
          x = exp_rd1.pop_front();
          chk("c1_rdata", {24'd0, c1_rdata}, {24'd0, x});
          chk("c1_latency", cyc - ack_cyc[1], 2);
        end
      end
    end
    rst_prev = reset;
    if (done) begin
      chk("wr_left", wr_q.size(), 0);
      chk("rdack_left", rdack_q.size(), 0);
      chk("rd0_left", exp_rd0.size(), 0);
      chk("rd1_left", exp_rd1.size(), 0);
      chk("ack_timeouts", tmo_cnt, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

endmodule
